// File: rtl/display_scan_if.sv
// Display bus between the time selector (master) and the scan driver (slave).
interface display_scan_if;
  logic [5:0] out_h;
  logic [5:0] out_m;
  logic [5:0] out_s;
  logic       alarm;
  logic       frame_start;

  modport master (
    output out_h,
    output out_m,
    output out_s,
    output alarm,
    input  frame_start
  );

  modport slave (
    input  out_h,
    input  out_m,
    input  out_s,
    input  alarm,
    output frame_start
  );
endinterface

// File: rtl/display_scan.sv
// Six-digit multiplexed 7-segment driver (HH MM SS). Snapshots the display bus once per
// frame, converts each pair to BCD and scans one digit slot at a time with a blanked lead-in
// per slot, colon decimal points and an alarm-driven whole-display blink.
module display_scan #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYC    = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             reset,
  display_scan_if.slave    bus,
  output logic [5:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int unsigned CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CntW-1:0]   CntLast   = CntW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {StLoad, StScan} state_e;

  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [5:0][3:0]     digit_q;
  logic                show_q;
  logic [BlinkW-1:0]   blink_cnt_q;
  logic                phase_on_q;
  logic [5:0]          an_d;
  logic [6:0]          seg_d;
  logic                dp_d;

  // Tens digit of a 0..63 value.
  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if      (v >= 6'd60) return 4'd6;
    else if (v >= 6'd50) return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    logic [5:0] t6;
    t6 = {2'b00, tens_of(v)};
    return 4'(v - t6 * 6'd10);
  endfunction

  // Active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Frame start is purely the LOAD state, suppressed while reset is held.
  assign bus.frame_start = (state_q == StLoad) && !reset;

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoad;
      idx_q   <= 3'd5;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scan FSM next state: one LOAD cycle, then six slots of SCAN_DIV cycles each.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLoad: begin
        state_d = StScan;
        idx_d   = 3'd5;
        cnt_d   = '0;
      end
      StScan: begin
        if (cnt_q == CntLast) begin
          if (idx_q == 3'd0) begin
            state_d = StLoad;
          end else begin
            idx_d = idx_q - 3'd1;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // Per-frame snapshot: BCD digits and blink phase are latched in the LOAD cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q     <= '0;
      show_q      <= 1'b1;
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
    end else if (state_q == StLoad) begin
      digit_q[5] <= tens_of(bus.out_h);
      digit_q[4] <= ones_of(bus.out_h);
      digit_q[3] <= tens_of(bus.out_m);
      digit_q[2] <= ones_of(bus.out_m);
      digit_q[1] <= tens_of(bus.out_s);
      digit_q[0] <= ones_of(bus.out_s);
      // This frame uses the current phase; any toggle applies from the next frame.
      show_q <= bus.alarm ? phase_on_q : 1'b1;
      if (!bus.alarm) begin
        blink_cnt_q <= '0;
        phase_on_q  <= 1'b1;
      end else if (blink_cnt_q == BlinkLast) begin
        blink_cnt_q <= '0;
        phase_on_q  <= ~phase_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // Display drive decode: lit only past the blank lead-in of a slot in a visible frame.
  always_comb begin
    an_d  = 6'h3F;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if ((state_q == StScan) && show_q && !(32'(cnt_q) < BLANK_CYC)) begin
      an_d  = ~(6'b000001 << idx_q);
      seg_d = seg_of(digit_q[idx_q]);
      dp_d  = !((idx_q == 3'd4) || (idx_q == 3'd2));
    end
  end

  // Registered display outputs, one cycle behind the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 6'h3F;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan with SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2. Expected frames are
// queued per scenario and each is driven and checked cycle by cycle as the DUT scans it.
module tb_display_scan;

  localparam int ScanDiv  = 8;
  localparam int BlankCyc = 2;
  localparam int FrameLen = 1 + 6 * ScanDiv;

  typedef struct {
    logic [5:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       alarm;
    bit         on;
  } frame_t;

  logic       clk;
  logic       reset;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  frame_t exp_q[$];
  int     tests;
  int     fails;

  display_scan_if bus ();

  display_scan #(
    .SCAN_DIV     (8),
    .BLANK_CYC    (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_model(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic frame_t mk(input int h, input int m, input int s, input bit al, input bit on);
    frame_t f;
    f.h = 6'(h);
    f.m = 6'(m);
    f.s = 6'(s);
    f.alarm = al;
    f.on = on;
    return f;
  endfunction

  // Entered at the negedge of a LOAD cycle; pops one expected frame, drives its inputs and
  // checks every cycle up to the next LOAD (or stops after cycle abort_at).
  task automatic check_frame(input int abort_at, input int chg_at, input logic [5:0] chg_h);
    frame_t     f;
    int         dig[6];
    int         j;
    int         idx;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fs;
    f = exp_q.pop_front();
    bus.out_h = f.h;
    bus.out_m = f.m;
    bus.out_s = f.s;
    bus.alarm = f.alarm;
    dig[5] = int'(f.h) / 10;
    dig[4] = int'(f.h) % 10;
    dig[3] = int'(f.m) / 10;
    dig[2] = int'(f.m) % 10;
    dig[1] = int'(f.s) / 10;
    dig[0] = int'(f.s) % 10;
    for (int n = 1; n <= FrameLen; n++) begin
      @(negedge clk);
      e_an  = 6'h3F;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_fs  = (n == FrameLen);
      if (n >= 2) begin
        j   = n - 2;
        idx = 5 - j / ScanDiv;
        if (f.on && (j % ScanDiv) >= BlankCyc) begin
          e_an  = ~(6'b000001 << idx);
          e_seg = seg_model(dig[idx]);
          e_dp  = !(idx == 4 || idx == 2);
        end
      end
      tests++;
      if ({an, seg, dp, bus.frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
        fails++;
        $display("FAIL frame h=%0d m=%0d s=%0d cyc=%0d: an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                 f.h, f.m, f.s, n, an, seg, dp, bus.frame_start, e_an, e_seg, e_dp, e_fs);
      end
      if (n == chg_at) bus.out_h = chg_h;
      if (n == abort_at) return;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_h = '0;
    bus.out_m = '0;
    bus.out_s = '0;
    bus.alarm = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({an, seg, dp, bus.frame_start} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL reset_hold: an=%h seg=%h dp=%b fs=%b, want 3f 7f 1 0",
                 an, seg, dp, bus.frame_start);
      end
    end
    reset = 1'b0;
    #1;
    tests++;
    if (bus.frame_start !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_load: fs=%b, want 1", bus.frame_start);
    end
  endtask

  task automatic test_basic();
    exp_q.push_back(mk(12, 34, 56, 1'b0, 1'b1));
    exp_q.push_back(mk(12, 34, 56, 1'b0, 1'b1));
    while (exp_q.size() > 0) check_frame(0, 0, '0);
  endtask

  task automatic test_values();
    exp_q.push_back(mk(63, 0, 9, 1'b0, 1'b1));
    exp_q.push_back(mk(59, 10, 0, 1'b0, 1'b1));
    while (exp_q.size() > 0) check_frame(0, 0, '0);
  endtask

  task automatic test_midframe();
    exp_q.push_back(mk(12, 34, 56, 1'b0, 1'b1));
    check_frame(0, 1, 6'd7);
    exp_q.push_back(mk(7, 34, 56, 1'b0, 1'b1));
    check_frame(0, 0, '0);
  endtask

  task automatic test_blink();
    bit al[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    bit on[8] = '{1, 1, 0, 0, 1, 1, 0, 1};
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(45, 21, 8, al[i], on[i]));
    while (exp_q.size() > 0) check_frame(0, 0, '0);
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(mk(12, 34, 56, 1'b0, 1'b1));
    // Stop with the FSM at idx=3, cnt=5 and reset on the next edge.
    check_frame(22, 0, '0);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({an, seg, dp, bus.frame_start} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid: an=%h seg=%h dp=%b fs=%b, want 3f 7f 1 0",
               an, seg, dp, bus.frame_start);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (bus.frame_start !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_load: fs=%b, want 1", bus.frame_start);
    end
    exp_q.push_back(mk(23, 59, 1, 1'b0, 1'b1));
    check_frame(0, 0, '0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_values();
    test_midframe();
    test_blink();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
